// File: rtl/systolic_row_ctrl.sv
// Command sequencer for one row of chained MAC blocks: drives the shared
// strobes, holds the value/weight-update vectors and returns one dot product per INFER.
module systolic_row_ctrl #(
    parameter int columns   = 64,
    parameter int datawidth = 11,
    parameter int CNT_W     = $clog2(columns + 1)
) (
    input  logic                           clk,
    input  logic                           rst_overall,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [1:0]                     cmd_op,
    input  logic [columns*datawidth-1:0]   cmd_data,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic signed [2*datawidth-1:0]  res_data,
    output logic                           res_sat,
    output logic [columns*datawidth-1:0]   arr_value,
    output logic [columns*datawidth-1:0]   arr_weight_update,
    output logic                           arr_train_en,
    output logic                           arr_rst_vals,
    output logic                           arr_wipe,
    input  logic signed [2*datawidth-1:0]  arr_chain_out,
    output logic                           busy
);

    localparam int AW = 2 * datawidth;
    localparam logic signed [AW-1:0] POS_SAT  = {1'b0, {(AW-1){1'b1}}};
    localparam logic signed [AW-1:0] NEG_SAT  = {1'b1, {(AW-1){1'b0}}};
    localparam logic [CNT_W-1:0]     RUN_LAST = CNT_W'(columns - 1);

    typedef enum logic [1:0] {
        OP_CLEAR = 2'b00,
        OP_TRAIN = 2'b01,
        OP_INFER = 2'b10,
        OP_WIPE  = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_CAPTURE,
        S_RESULT,
        S_TRAIN,
        S_WIPE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             infer_pending;

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst_overall) begin
            state             <= S_IDLE;
            cnt               <= '0;
            infer_pending     <= 1'b0;
            arr_value         <= '0;
            arr_weight_update <= '0;
            res_data          <= '0;
            res_valid         <= 1'b0;
            res_sat           <= 1'b0;
            arr_train_en      <= 1'b0;
            arr_rst_vals      <= 1'b0;
            arr_wipe          <= 1'b0;
        end else begin
            // Strobes are raised on the edge that enters their state, so each
            // is a registered pulse that lines up exactly with that state.
            arr_train_en <= 1'b0;
            arr_rst_vals <= 1'b0;
            arr_wipe     <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        case (op_t'(cmd_op))
                            OP_CLEAR: begin
                                state         <= S_CLEAR;
                                arr_rst_vals  <= 1'b1;
                                infer_pending <= 1'b0;
                            end
                            OP_INFER: begin
                                state         <= S_CLEAR;
                                arr_rst_vals  <= 1'b1;
                                infer_pending <= 1'b1;
                                arr_value     <= cmd_data;
                            end
                            OP_TRAIN: begin
                                state             <= S_TRAIN;
                                arr_train_en      <= 1'b1;
                                arr_weight_update <= cmd_data;
                            end
                            OP_WIPE: begin
                                state    <= S_WIPE;
                                arr_wipe <= 1'b1;
                            end
                        endcase
                    end
                end
                S_CLEAR: begin
                    cnt   <= '0;
                    state <= infer_pending ? S_RUN : S_IDLE;
                end
                S_RUN: begin
                    if (cnt == RUN_LAST) begin
                        cnt   <= '0;
                        state <= S_CAPTURE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    res_data  <= arr_chain_out;
                    res_sat   <= (arr_chain_out == POS_SAT) || (arr_chain_out == NEG_SAT);
                    res_valid <= 1'b1;
                    state     <= S_RESULT;
                end
                S_RESULT: begin
                    if (res_ready) begin
                        res_valid     <= 1'b0;
                        infer_pending <= 1'b0;
                        state         <= S_IDLE;
                    end
                end
                S_TRAIN: state <= S_IDLE;
                S_WIPE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_row_ctrl.sv
// Self-checking bench: a behavioural MAC row around the controller plus a
// dot-product reference model driven by the commands issued.
module tb_systolic_row_ctrl;

    localparam int COLS = 4;
    localparam int DW   = 11;
    localparam int AW   = 2 * DW;
    localparam longint POS = (64'sd1 <<< (AW - 1)) - 1;
    localparam longint NEG = -(64'sd1 <<< (AW - 1));

    localparam logic [1:0] OP_CLEAR = 2'b00;
    localparam logic [1:0] OP_TRAIN = 2'b01;
    localparam logic [1:0] OP_INFER = 2'b10;
    localparam logic [1:0] OP_WIPE  = 2'b11;

    logic                    clk = 1'b0;
    logic                    rst_overall = 1'b1;
    logic                    cmd_valid = 1'b0;
    logic                    cmd_ready;
    logic [1:0]              cmd_op = 2'b00;
    logic [COLS*DW-1:0]      cmd_data = '0;
    logic                    res_valid;
    logic                    res_ready = 1'b0;
    logic signed [AW-1:0]    res_data;
    logic                    res_sat;
    logic [COLS*DW-1:0]      arr_value;
    logic [COLS*DW-1:0]      arr_weight_update;
    logic                    arr_train_en;
    logic                    arr_rst_vals;
    logic                    arr_wipe;
    logic signed [AW-1:0]    arr_chain_out;
    logic                    busy;

    int checks = 0;
    int fails  = 0;
    int n_train = 0, n_rst = 0, n_wipe = 0;

    int ref_w   [COLS];
    int ref_val [COLS];
    int vec     [COLS];

    systolic_row_ctrl #(
        .columns   (COLS),
        .datawidth (DW),
        .CNT_W     ($clog2(COLS + 1))
    ) dut (
        .clk               (clk),
        .rst_overall       (rst_overall),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_op            (cmd_op),
        .cmd_data          (cmd_data),
        .res_valid         (res_valid),
        .res_ready         (res_ready),
        .res_data          (res_data),
        .res_sat           (res_sat),
        .arr_value         (arr_value),
        .arr_weight_update (arr_weight_update),
        .arr_train_en      (arr_train_en),
        .arr_rst_vals      (arr_rst_vals),
        .arr_wipe          (arr_wipe),
        .arr_chain_out     (arr_chain_out),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    function automatic int sat_w(input longint x);
        if (x > 1023) return 1023;
        if (x < -1024) return -1024;
        return int'(x);
    endfunction

    function automatic longint sat_acc(input longint x);
        if (x > POS) return POS;
        if (x < NEG) return NEG;
        return x;
    endfunction

    function automatic logic [COLS*DW-1:0] pack_vec();
        logic [COLS*DW-1:0] p;
        p = '0;
        for (int k = 0; k < COLS; k++) p[k*DW +: DW] = vec[k][DW-1:0];
        return p;
    endfunction

    function automatic longint ref_dot();
        longint s;
        s = 0;
        for (int k = 0; k < COLS; k++) s += longint'(ref_val[k]) * longint'(ref_w[k]);
        return sat_acc(s);
    endfunction

    // Behavioural row of MAC blocks: weights wiped by system reset or arr_wipe,
    // each column adds value*weight to its west neighbour's registered sum.
    logic signed [DW-1:0] stub_w [COLS];
    logic signed [AW-1:0] psum   [COLS];
    assign arr_chain_out = psum[COLS-1];

    always @(posedge clk) begin
        if (rst_overall || arr_wipe) begin
            for (int k = 0; k < COLS; k++) begin
                stub_w[k] <= '0;
                psum[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < COLS; k++) begin
                longint prev, prod;
                prev = 0;
                if (k > 0) prev = longint'(psum[k-1]);
                prod = longint'(stub_w[k]) * longint'($signed(arr_value[k*DW +: DW]));
                if (arr_train_en)
                    stub_w[k] <= DW'(sat_w(longint'(stub_w[k]) +
                                           longint'($signed(arr_weight_update[k*DW +: DW]))));
                if (arr_rst_vals) psum[k] <= '0;
                else              psum[k] <= AW'(sat_acc(prev + prod));
            end
        end
    end

    always @(negedge clk) begin
        n_train += int'(arr_train_en);
        n_rst   += int'(arr_rst_vals);
        n_wipe  += int'(arr_wipe);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails + 1);
        $fatal(1, "watchdog");
    end

    // Called at a negedge; returns one negedge after the accepting edge.
    task automatic send_cmd(input logic [1:0] op, output bit ok);
        int g;
        g = 0;
        while (!cmd_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        ok = cmd_ready;
        if (!ok) return;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = pack_vec();
        @(negedge clk);
        cmd_valid = 1'b0;
        case (op)
            OP_TRAIN: for (int k = 0; k < COLS; k++) ref_w[k] = sat_w(longint'(ref_w[k]) + vec[k]);
            OP_WIPE:  for (int k = 0; k < COLS; k++) ref_w[k] = 0;
            OP_INFER: for (int k = 0; k < COLS; k++) ref_val[k] = vec[k];
            default: ;
        endcase
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!res_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic take_result();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic set_vec(input int a0, input int a1, input int a2, input int a3);
        vec[0] = a0; vec[1] = a1; vec[2] = a2; vec[3] = a3;
    endtask

    task automatic test_reset();
        rst_overall = 1'b1;
        repeat (2) @(negedge clk);
        rst_overall = 1'b0;
        for (int k = 0; k < COLS; k++) begin ref_w[k] = 0; ref_val[k] = 0; end
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (res_valid !== 1'b0 || res_sat !== 1'b0) begin fails++; $display("FAIL reset_res_flags got=%b%b exp=00", res_valid, res_sat); end
        checks++; if (res_data !== '0) begin fails++; $display("FAIL reset_res_data got=%0d exp=0", res_data); end
        checks++; if ({arr_train_en, arr_rst_vals, arr_wipe} !== 3'b000) begin fails++; $display("FAIL reset_strobes got=%b exp=000", {arr_train_en, arr_rst_vals, arr_wipe}); end
        checks++; if (arr_value !== '0 || arr_weight_update !== '0) begin fails++; $display("FAIL reset_vectors got=%h/%h exp=0", arr_value, arr_weight_update); end
    endtask

    task automatic test_basic();
        bit ok; int lat, t0, r0; longint exp;
        set_vec(0, 0, 0, 0);
        send_cmd(OP_WIPE, ok);
        checks++; if (!ok) begin fails++; $display("FAIL basic_wipe_accept got=timeout exp=accepted"); end
        checks++; if ({arr_train_en, arr_rst_vals, arr_wipe} !== 3'b001) begin fails++; $display("FAIL basic_wipe_pulse got=%b exp=001", {arr_train_en, arr_rst_vals, arr_wipe}); end
        @(negedge clk);
        checks++; if (arr_wipe !== 1'b0 || cmd_ready !== 1'b1) begin fails++; $display("FAIL basic_wipe_done got=wipe%b rdy%b exp=wipe0 rdy1", arr_wipe, cmd_ready); end

        set_vec(1, 2, 3, 4);
        t0 = n_train;
        send_cmd(OP_TRAIN, ok);
        checks++; if ({arr_train_en, arr_rst_vals, arr_wipe} !== 3'b100) begin fails++; $display("FAIL basic_train_pulse got=%b exp=100", {arr_train_en, arr_rst_vals, arr_wipe}); end
        repeat (3) @(negedge clk);
        checks++; if (n_train - t0 !== 1) begin fails++; $display("FAIL basic_train_len got=%0d exp=1", n_train - t0); end
        checks++; if (arr_weight_update !== pack_vec()) begin fails++; $display("FAIL basic_wupd got=%h exp=%h", arr_weight_update, pack_vec()); end

        set_vec(5, 6, 7, 8);
        r0 = n_rst;
        send_cmd(OP_INFER, ok);
        wait_result(lat);
        exp = ref_dot();
        checks++; if (lat !== COLS + 2) begin fails++; $display("FAIL basic_latency got=%0d exp=%0d", lat, COLS + 2); end
        checks++; if (longint'(res_data) !== exp) begin fails++; $display("FAIL basic_res_data got=%0d exp=%0d", res_data, exp); end
        checks++; if (res_sat !== 1'b0) begin fails++; $display("FAIL basic_res_sat got=%b exp=0", res_sat); end
        checks++; if (n_rst - r0 !== 1) begin fails++; $display("FAIL basic_rst_vals_len got=%0d exp=1", n_rst - r0); end
        checks++; if (arr_value !== pack_vec()) begin fails++; $display("FAIL basic_value got=%h exp=%h", arr_value, pack_vec()); end
        take_result();
        checks++; if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin fails++; $display("FAIL basic_handshake got=v%b r%b exp=v0 r1", res_valid, cmd_ready); end
        checks++; if (longint'(res_data) !== exp) begin fails++; $display("FAIL basic_data_kept got=%0d exp=%0d", res_data, exp); end
    endtask

    task automatic test_back_to_back();
        bit ok; int lat, t0; longint exp; logic [COLS*DW-1:0] held;
        set_vec(5, 6, 7, 8);
        send_cmd(OP_INFER, ok);
        held = arr_value;
        wait_result(lat);
        exp = ref_dot();
        checks++; if (lat !== COLS + 2) begin fails++; $display("FAIL bp_latency got=%0d exp=%0d", lat, COLS + 2); end
        set_vec(1, 1, 1, 1);
        cmd_valid = 1'b1; cmd_op = OP_TRAIN; cmd_data = pack_vec();
        t0 = n_train;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++; if (longint'(res_data) !== exp || res_valid !== 1'b1) begin fails++; $display("FAIL bp_hold[%0d] got=%0d v%b exp=%0d v1", i, res_data, res_valid, exp); end
            checks++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL bp_cmd_ready[%0d] got=%b exp=0", i, cmd_ready); end
        end
        checks++; if (n_train !== t0 || arr_value !== held) begin fails++; $display("FAIL bp_no_effect got=train%0d exp=0", n_train - t0); end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checks++; if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin fails++; $display("FAIL bp_release got=r%b v%b exp=r1 v0", cmd_ready, res_valid); end
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int k = 0; k < COLS; k++) ref_w[k] = sat_w(longint'(ref_w[k]) + vec[k]);
        checks++; if (arr_train_en !== 1'b1) begin fails++; $display("FAIL bp_train_after got=%b exp=1", arr_train_en); end
        @(negedge clk);
    endtask

    task automatic test_saturation();
        bit ok; int lat;
        set_vec(1023, 1023, 1023, 1023);
        send_cmd(OP_TRAIN, ok);
        @(negedge clk);
        send_cmd(OP_INFER, ok);
        wait_result(lat);
        checks++; if (longint'(res_data) !== ref_dot() || longint'(res_data) !== POS) begin fails++; $display("FAIL sat_pos_data got=%0d exp=%0d", res_data, ref_dot()); end
        checks++; if (res_sat !== 1'b1) begin fails++; $display("FAIL sat_pos_flag got=%b exp=1", res_sat); end
        take_result();

        send_cmd(OP_WIPE, ok);
        @(negedge clk);
        set_vec(-1024, -1024, -1024, -1024);
        send_cmd(OP_TRAIN, ok);
        @(negedge clk);
        set_vec(1023, 1023, 1023, 1023);
        send_cmd(OP_INFER, ok);
        wait_result(lat);
        checks++; if (longint'(res_data) !== ref_dot() || longint'(res_data) !== NEG) begin fails++; $display("FAIL sat_neg_data got=%0d exp=%0d", res_data, ref_dot()); end
        checks++; if (res_sat !== 1'b1) begin fails++; $display("FAIL sat_neg_flag got=%b exp=1", res_sat); end
        take_result();
    endtask

    task automatic test_mid_reset();
        bit ok; bit seen;
        set_vec(11, -7, 3, 2);
        send_cmd(OP_INFER, ok);
        repeat (3) @(negedge clk);
        rst_overall = 1'b1;
        @(negedge clk);
        rst_overall = 1'b0;
        for (int k = 0; k < COLS; k++) begin ref_w[k] = 0; ref_val[k] = 0; end
        checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL midrst_idle got=r%b b%b exp=r1 b0", cmd_ready, busy); end
        checks++; if ({arr_train_en, arr_rst_vals, arr_wipe} !== 3'b000) begin fails++; $display("FAIL midrst_strobes got=%b exp=000", {arr_train_en, arr_rst_vals, arr_wipe}); end
        checks++; if (arr_value !== '0) begin fails++; $display("FAIL midrst_value got=%h exp=0", arr_value); end
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (res_valid) seen = 1'b1;
            @(negedge clk);
        end
        checks++; if (seen !== 1'b0) begin fails++; $display("FAIL midrst_no_result got=%b exp=0", seen); end
    endtask

    task automatic test_clear_negmix();
        bit ok; int lat, r0; logic [COLS*DW-1:0] held;
        held = arr_value;
        set_vec(99, 98, 97, 96);
        r0 = n_rst;
        send_cmd(OP_CLEAR, ok);
        checks++; if (arr_rst_vals !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL clear_pulse got=rv%b b%b exp=rv1 b1", arr_rst_vals, busy); end
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL clear_idle got=%b exp=1", cmd_ready); end
        checks++; if (n_rst - r0 !== 1) begin fails++; $display("FAIL clear_len got=%0d exp=1", n_rst - r0); end
        checks++; if (arr_value !== held || res_valid !== 1'b0) begin fails++; $display("FAIL clear_no_latch got=%h v%b exp=%h v0", arr_value, res_valid, held); end

        send_cmd(OP_WIPE, ok);
        @(negedge clk);
        set_vec(-3, 2, 0, 7);
        send_cmd(OP_TRAIN, ok);
        @(negedge clk);
        set_vec(4, -5, 9, 1);
        send_cmd(OP_INFER, ok);
        wait_result(lat);
        checks++; if (longint'(res_data) !== ref_dot() || longint'(res_data) !== -15) begin fails++; $display("FAIL negmix_data got=%0d exp=%0d", res_data, ref_dot()); end
        checks++; if (res_sat !== 1'b0) begin fails++; $display("FAIL negmix_sat got=%b exp=0", res_sat); end
        take_result();
    endtask

    task automatic test_random();
        bit ok; int lat; int op; longint exp; bit exp_sat;
        for (int it = 0; it < 30; it++) begin
            op = int'($urandom_range(0, 3));
            for (int k = 0; k < COLS; k++)
                vec[k] = (op == int'(OP_TRAIN)) ? int'($urandom_range(0, 100)) - 50
                                                : int'($urandom_range(0, 200)) - 100;
            send_cmd(op[1:0], ok);
            checks++; if (!ok) begin fails++; $display("FAIL rnd_accept[%0d] got=timeout exp=accepted", it); end
            if (op == int'(OP_INFER)) begin
                wait_result(lat);
                exp = ref_dot();
                exp_sat = (exp == POS) || (exp == NEG);
                checks++; if (lat !== COLS + 2) begin fails++; $display("FAIL rnd_latency[%0d] got=%0d exp=%0d", it, lat, COLS + 2); end
                checks++; if (longint'(res_data) !== exp || res_sat !== exp_sat) begin fails++; $display("FAIL rnd_result[%0d] got=%0d/%b exp=%0d/%b", it, res_data, res_sat, exp, exp_sat); end
                repeat ($urandom_range(0, 3)) @(negedge clk);
                take_result();
            end else begin
                checks++; if ({arr_train_en, arr_rst_vals, arr_wipe} !== {op == int'(OP_TRAIN), op == int'(OP_CLEAR), op == int'(OP_WIPE)}) begin
                    fails++; $display("FAIL rnd_strobe[%0d] got=%b op=%0d", it, {arr_train_en, arr_rst_vals, arr_wipe}, op);
                end
                @(negedge clk);
                checks++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL rnd_idle[%0d] got=%b exp=1", it, cmd_ready); end
                if (op == int'(OP_TRAIN)) begin
                    checks++; if (arr_weight_update !== pack_vec()) begin fails++; $display("FAIL rnd_wupd[%0d] got=%h exp=%h", it, arr_weight_update, pack_vec()); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_saturation();
        test_mid_reset();
        test_clear_negmix();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
